// File: rtl/shift_loop_pkg.sv
// Shared definitions for the serial loop-back controller: FSM encoding and
// the transfer counter width helper.
package shift_loop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter must reach WIDTH+DEPTH-1 without wrapping.
    function automatic int cnt_width(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/shift_loop_ctrl.sv
// Serialises a word LSB first into an external free-running flop chain and
// reassembles the word returning from the chain tail, flagging corruption.
module shift_loop_ctrl
    import shift_loop_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    input  logic             ser_in,
    input  logic             abort,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             err,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH, DEPTH);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_CAP   = CNT_W'(WIDTH + DEPTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] word_q, word_nxt;
    logic [WIDTH-1:0] data_nxt, cap_data, shifted;
    logic             err_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            word_q   <= '0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            word_q   <= word_nxt;
            out_data <= data_nxt;
            err      <= err_nxt;
        end
    end

    // The bit driven at count k returns DEPTH cycles later, so the capture
    // slot trails the drive slot by DEPTH counts across SHIFT and FLUSH.
    always_comb begin
        cap_data = out_data;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CNT_W'(i + DEPTH))
                cap_data[i] = ser_in;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word_q;
        data_nxt  = out_data;
        err_nxt   = err;
        if (abort) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_nxt  = in_data;
                        cnt_nxt   = '0;
                        data_nxt  = '0;
                        err_nxt   = 1'b0;
                        state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT, ST_FLUSH: begin
                    cnt_nxt  = cnt + 1'b1;
                    data_nxt = cap_data;
                    if (cnt == LAST_CAP) begin
                        state_nxt = ST_DONE;
                        err_nxt   = (cap_data != word_q);
                    end else if (state == ST_SHIFT && cnt == LAST_SHIFT) begin
                        state_nxt = ST_FLUSH;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b0;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        shifted   = word_q >> cnt;
        ser_out   = (state == ST_SHIFT) ? shifted[0] : 1'b0;
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_shift_loop_ctrl.sv
// Directed bench for shift_loop_ctrl with a DEPTH-stage loop-back chain.
module tb_shift_loop_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_out, ser_in;
    logic             abort;
    logic             out_valid, out_ready, err, busy;
    logic [WIDTH-1:0] out_data;
    logic [DEPTH-1:0] chain;
    logic             force_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       fz;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    always #5 clock = ~clock;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) chain <= '0;
        else        chain <= {chain[DEPTH-2:0], ser_out};
    end

    assign ser_in = force_zero ? 1'b0 : chain[DEPTH-1];

    shift_loop_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_in    (ser_in),
        .abort     (abort),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .err       (err),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts in IDLE; accepts d, checks the serial stream and the DONE result.
    task automatic send_and_check(input logic [7:0] d, input logic [7:0] exp_d,
                                  input logic exp_e, input bit release_ready);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            chk("ser_out_bit", 32'(ser_out), 32'(d[i]));
            chk("out_valid_early", 32'(out_valid), 32'd0);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            chk("ser_out_flush", 32'(ser_out), 32'd0);
            chk("out_valid_early", 32'(out_valid), 32'd0);
            tick();
        end
        chk("out_valid_done", 32'(out_valid), 32'd1);
        chk("out_data", 32'(out_data), 32'(exp_d));
        chk("err", 32'(err), 32'(exp_e));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        chk("busy_done", 32'(busy), 32'd1);
        if (release_ready) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("out_valid_release", 32'(out_valid), 32'd0);
            chk("in_ready_release", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h5A, 1'b0, 8'h5A, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 8'h00, 1'b1};

        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        force_zero = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ser_out", 32'(ser_out), 32'd0);
        #10 reset = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            force_zero = vecs[v].fz;
            send_and_check(vecs[v].data, vecs[v].exp_data, vecs[v].exp_err, 1'b1);
            force_zero = 1'b0;
        end

        // Stall in DONE, then release with a competing in_valid.
        send_and_check(8'hA5, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_data", 32'(out_data), 32'hA5);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("hold_release_busy", 32'(busy), 32'd0);
        chk("hold_release_in_ready", 32'(in_ready), 32'd1);
        chk("hold_release_out_valid", 32'(out_valid), 32'd0);

        // Abort with cnt=3 in SHIFT.
        in_valid = 1'b1;
        in_data  = 8'hC3;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_ser_out", 32'(ser_out), 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_out_valid", 32'(out_valid), 32'd0);
            tick();
        end

        // Reset asserted mid-cycle while in FLUSH.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("flush_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ser_out", 32'(ser_out), 32'd0);
        #3 reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_no_out", 32'(out_valid), 32'd0);
            tick();
        end
        send_and_check(8'hFF, 8'hFF, 1'b0, 1'b1);

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < WIDTH + DEPTH; i++) tick();
        chk("b2b_first_valid", 32'(out_valid), 32'd1);
        chk("b2b_first_data", 32'(out_data), 32'h01);
        chk("b2b_first_err", 32'(err), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h80;
        tick();
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        chk("b2b_gap_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < WIDTH + DEPTH; i++) tick();
        chk("b2b_second_valid", 32'(out_valid), 32'd1);
        chk("b2b_second_data", 32'(out_data), 32'h80);
        chk("b2b_second_err", 32'(err), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("b2b_end_idle", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
